// File: rtl/l3_pkg.sv
// Shared L3 definitions: line geometry and fill-engine state encoding.
// Imported by the fill engine and the L3 cache.
package l3_pkg;

  localparam int L3_DATA_WIDTH  = 32;
  localparam int L3_ADDR_WIDTH  = 32;
  localparam int L3_LINE_SIZE   = 16;
  localparam int BYTES_PER_WORD = L3_DATA_WIDTH / 8;
  localparam int WORDS_PER_LINE = L3_LINE_SIZE / BYTES_PER_WORD;
  localparam int OFFSET_BITS    = $clog2(L3_LINE_SIZE);
  localparam int LINE_BITS      = L3_LINE_SIZE * 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FILL,
    RESP
  } fill_state_t;

endpackage

// File: rtl/l3_line_fill_engine.sv
// L3 miss-side line fill sequencer: reads a line from RAM one word at a
// time, writes it into L3 with a single fill pulse, and returns it upstream.
module l3_line_fill_engine
  import l3_pkg::*;
#(
  parameter int DATA_WIDTH = L3_DATA_WIDTH,
  parameter int ADDR_WIDTH = L3_ADDR_WIDTH,
  parameter int LINE_SIZE  = L3_LINE_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_no_alloc,
  output logic                   req_ready,
  output logic                   ram_rd_en,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic                   ram_rd_valid,
  input  logic [DATA_WIDTH-1:0]  ram_rd_data,
  output logic                   fill_en,
  output logic [ADDR_WIDTH-1:0]  fill_addr,
  output logic [LINE_SIZE*8-1:0] fill_data,
  output logic                   fill_mark_valid,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LINE_SIZE*8-1:0] resp_data,
  output logic                   busy
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int WPL   = LINE_SIZE / BPW;
  localparam int OFF   = $clog2(LINE_SIZE);
  localparam int WSH   = $clog2(BPW);
  localparam int LBITS = LINE_SIZE * 8;
  localparam int BW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [BW-1:0] LAST = BW'(WPL - 1);

  fill_state_t           state;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] base;
  logic                  no_alloc;
  logic [LBITS-1:0]      line;
  logic [LBITS-1:0]      line_nxt;
  logic [ADDR_WIDTH-1:0] req_base;

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [BW-1:0]         n
  );
    return b + (ADDR_WIDTH'(n) << WSH);
  endfunction

  assign req_base = {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign busy     = ~req_ready;

  // Line buffer with the arriving word merged into the current beat slot.
  always_comb begin
    line_nxt = line;
    line_nxt[beat*DATA_WIDTH +: DATA_WIDTH] = ram_rd_data;
  end

  // Fill FSM with registered handshake, RAM and fill outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= '0;
      base            <= '0;
      no_alloc        <= 1'b0;
      line            <= '0;
      req_ready       <= 1'b1;
      ram_rd_en       <= 1'b0;
      ram_addr        <= '0;
      fill_en         <= 1'b0;
      fill_addr       <= '0;
      fill_data       <= '0;
      fill_mark_valid <= 1'b0;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
    end else begin
      ram_rd_en       <= 1'b0;
      fill_en         <= 1'b0;
      fill_mark_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            base      <= req_base;
            no_alloc  <= req_no_alloc;
            beat      <= '0;
            ram_rd_en <= 1'b1;
            ram_addr  <= req_base;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (ram_rd_valid) begin
            line <= line_nxt;
            if (beat == LAST) begin
              if (no_alloc) begin
                resp_valid <= 1'b1;
                resp_data  <= line_nxt;
                state      <= RESP;
              end else begin
                fill_en         <= 1'b1;
                fill_mark_valid <= 1'b1;
                fill_addr       <= base;
                fill_data       <= line_nxt;
                state           <= FILL;
              end
            end else begin
              beat      <= beat + 1'b1;
              ram_rd_en <= 1'b1;
              ram_addr  <= beat_addr(base, beat + 1'b1);
              state     <= ISSUE;
            end
          end
        end
        FILL: begin
          resp_valid <= 1'b1;
          resp_data  <= line;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_line_fill_engine.sv
// Bench for l3_line_fill_engine: directed scenarios plus randomized
// transactions checked against a line/latency reference model.
module tb_l3_line_fill_engine;

  logic         clk = 0;
  logic         rst = 1;
  logic         req_valid = 0;
  logic [31:0]  req_addr = 0;
  logic         req_no_alloc = 0;
  logic         req_ready;
  logic         ram_rd_en;
  logic [31:0]  ram_addr;
  logic         ram_rd_valid = 0;
  logic [31:0]  ram_rd_data = 0;
  logic         fill_en;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         fill_mark_valid;
  logic         resp_valid;
  logic         resp_ready = 0;
  logic [127:0] resp_data;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  l3_line_fill_engine dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_no_alloc(req_no_alloc), .req_ready(req_ready),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .fill_en(fill_en), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_mark_valid(fill_mark_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Per-transaction stimulus and observations.
  logic [31:0]  dwords [4];
  int           lat [4];
  logic [31:0]  got_addrs [$];
  int           rd_en_cnt, overlap_err, hold_err, fill_cnt;
  int           resp_cyc, stable_err, busy_err;
  logic [31:0]  fill_addr_q;
  logic [127:0] fill_data_q, resp_data_q;
  logic         fill_mark_q, post_ready, post_resp, post_rd_en;

  function automatic logic [31:0] exp_addr(logic [31:0] a, int k);
    return (a & 32'hFFFF_FFF0) + 32'(4 * k);
  endfunction

  function automatic logic [127:0] exp_line();
    return {dwords[3], dwords[2], dwords[1], dwords[0]};
  endfunction

  function automatic int exp_resp_cyc(bit na);
    int t = 1;
    for (int k = 0; k < 4; k++) t += 1 + lat[k];
    return na ? t : t + 1;
  endfunction

  function automatic int addr_errs(logic [31:0] a);
    int bad = 0;
    if (got_addrs.size() != 4) return 99;
    for (int k = 0; k < 4; k++)
      if (got_addrs[k] !== exp_addr(a, k)) bad++;
    return bad;
  endfunction

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] addr, input bit na,
                         input int hold, input bit inject);
    int cyc, beat, cd, held;
    bit pend, done_hs;
    logic [31:0] hold_q;
    got_addrs.delete();
    rd_en_cnt = 0; overlap_err = 0; hold_err = 0; fill_cnt = 0;
    resp_cyc = -1; stable_err = 0; busy_err = 0;
    fill_addr_q = 0; fill_data_q = 0; fill_mark_q = 0; resp_data_q = 0;
    cyc = 0;
    while (!req_ready && cyc < 50) begin do_cycle(); cyc++; end
    req_valid = 1; req_addr = addr; req_no_alloc = na;
    do_cycle();
    req_valid = 0; req_addr = $urandom; req_no_alloc = 1'($urandom);
    cyc = 1; beat = 0; pend = 0; cd = 0; done_hs = 0; held = 0; hold_q = 0;
    while (!done_hs && cyc < 300) begin
      ram_rd_valid = 0;
      ram_rd_data = $urandom;
      if (pend && !ram_rd_en && ram_addr !== hold_q) hold_err++;
      if (pend) begin
        cd--;
        if (cd <= 0) begin
          ram_rd_valid = 1;
          ram_rd_data = dwords[beat < 4 ? beat : 3];
          pend = 0;
          beat++;
        end
      end
      if (ram_rd_en) begin
        rd_en_cnt++;
        if (pend) overlap_err++;
        got_addrs.push_back(ram_addr);
        hold_q = ram_addr;
        pend = 1;
        cd = lat[beat < 4 ? beat : 3];
      end
      if (fill_en) begin
        fill_cnt++;
        fill_addr_q = fill_addr;
        fill_data_q = fill_data;
        fill_mark_q = fill_mark_valid;
      end
      if (resp_valid) begin
        if (resp_cyc < 0) begin
          resp_cyc = cyc; resp_data_q = resp_data; held = hold;
        end else if (resp_data !== resp_data_q) stable_err++;
        if (req_ready !== 1'b0 || busy !== 1'b1) busy_err++;
        if (held > 0) begin
          held--;
          req_valid = inject;
          req_addr = addr ^ 32'h0000_0100;
        end else begin
          resp_ready = 1; req_valid = 0; done_hs = 1;
        end
      end
      do_cycle();
      cyc++;
    end
    resp_ready = 0;
    ram_rd_valid = 0;
    post_ready = req_ready;
    post_resp = resp_valid;
    post_rd_en = ram_rd_en;
    if (!done_hs) begin
      tests_run++; tests_failed++;
      $display("FAIL txn_timeout: addr %h no response within budget", addr);
      rst = 1; do_cycle(); rst = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    do_cycle(); do_cycle();
    rst = 0;
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
    end
    tests_run++;
    if ({ram_rd_en, ram_addr, fill_en, fill_addr, fill_mark_valid} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got rd_en=%b addr=%h fill=%b faddr=%h mark=%b want 0",
               ram_rd_en, ram_addr, fill_en, fill_addr, fill_mark_valid);
    end
    tests_run++;
    if ({resp_valid, resp_data, fill_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got rv=%b rd=%h fd=%h want 0", resp_valid, resp_data, fill_data);
    end
  endtask

  task automatic test_basic();
    dwords = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    lat = '{1, 1, 1, 1};
    run_txn(32'h0000_1238, 0, 0, 0);
    tests_run++;
    if (addr_errs(32'h0000_1238) != 0) begin
      tests_failed++;
      $display("FAIL basic_addrs: got %p want 1230,1234,1238,123c", got_addrs);
    end
    tests_run++;
    if (fill_cnt != 1 || fill_addr_q !== 32'h1230 || fill_mark_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_fill: got cnt=%0d addr=%h mark=%b want 1/1230/1",
               fill_cnt, fill_addr_q, fill_mark_q);
    end
    tests_run++;
    if (fill_data_q !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      tests_failed++;
      $display("FAIL basic_fill_data: got %h want %h", fill_data_q,
               128'h000000A3_000000A2_000000A1_000000A0);
    end
    tests_run++;
    if (resp_cyc != 10 || resp_data_q !== exp_line()) begin
      tests_failed++;
      $display("FAIL basic_resp: got cyc=%0d data=%h want 10/%h", resp_cyc, resp_data_q, exp_line());
    end
    tests_run++;
    if (post_ready !== 1'b1 || post_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release: got ready=%b rv=%b want 1/0", post_ready, post_resp);
    end
  endtask

  task automatic test_no_alloc();
    dwords = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    lat = '{1, 1, 1, 1};
    run_txn(32'h0000_1238, 1, 0, 0);
    tests_run++;
    if (fill_cnt != 0) begin
      tests_failed++;
      $display("FAIL noalloc_fill: got %0d fills want 0", fill_cnt);
    end
    tests_run++;
    if (resp_cyc != 9 || resp_data_q !== exp_line()) begin
      tests_failed++;
      $display("FAIL noalloc_resp: got cyc=%0d data=%h want 9/%h", resp_cyc, resp_data_q, exp_line());
    end
  endtask

  task automatic test_slow_beat();
    for (int k = 0; k < 4; k++) dwords[k] = $urandom;
    lat = '{1, 1, 5, 1};
    run_txn(32'h0000_1238, 0, 0, 0);
    tests_run++;
    if (rd_en_cnt != 4 || overlap_err != 0 || addr_errs(32'h1238) != 0) begin
      tests_failed++;
      $display("FAIL slow_issue: got rd_en=%0d overlap=%0d addrs=%p want 4/0/1230..123c",
               rd_en_cnt, overlap_err, got_addrs);
    end
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++;
      $display("FAIL slow_hold: got %0d addr changes while waiting want 0", hold_err);
    end
    tests_run++;
    if (resp_cyc != exp_resp_cyc(0) || resp_data_q !== exp_line()) begin
      tests_failed++;
      $display("FAIL slow_resp: got cyc=%0d data=%h want %0d/%h",
               resp_cyc, resp_data_q, exp_resp_cyc(0), exp_line());
    end
  endtask

  task automatic test_resp_stall();
    for (int k = 0; k < 4; k++) dwords[k] = $urandom;
    lat = '{1, 2, 1, 3};
    run_txn(32'h0000_4000, 0, 3, 1);
    tests_run++;
    if (stable_err != 0 || busy_err != 0) begin
      tests_failed++;
      $display("FAIL stall_stable: got data_changes=%0d ready_errs=%0d want 0/0", stable_err, busy_err);
    end
    tests_run++;
    if (resp_data_q !== exp_line() || rd_en_cnt != 4) begin
      tests_failed++;
      $display("FAIL stall_data: got %h rd_en=%0d want %h/4", resp_data_q, rd_en_cnt, exp_line());
    end
    tests_run++;
    if (post_ready !== 1'b1 || post_rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_ignored_req: got ready=%b rd_en=%b want 1/0", post_ready, post_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    int fills = 0;
    while (!req_ready) do_cycle();
    req_valid = 1; req_addr = 32'h0000_1238; req_no_alloc = 0;
    do_cycle();
    req_valid = 0;
    fills += fill_en;
    do_cycle();
    ram_rd_valid = 1; ram_rd_data = 32'h0000_00B0;
    fills += fill_en;
    do_cycle();
    ram_rd_valid = 0;
    fills += fill_en;
    do_cycle();
    fills += fill_en;
    rst = 1;
    do_cycle();
    rst = 0;
    fills += fill_en;
    tests_run++;
    if (req_ready !== 1'b1 || {ram_rd_en, ram_addr, resp_valid, resp_data} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_state: got ready=%b rd_en=%b addr=%h rv=%b want 1/0/0/0",
               req_ready, ram_rd_en, ram_addr, resp_valid);
    end
    ram_rd_valid = 1; ram_rd_data = 32'h0000_00FF;
    do_cycle();
    ram_rd_valid = 0;
    fills += fill_en;
    do_cycle();
    fills += fill_en;
    tests_run++;
    if (fills != 0 || req_ready !== 1'b1 || {fill_data, resp_data, ram_rd_en} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_stray: got fills=%0d ready=%b fd=%h rd=%h want 0/1/0/0",
               fills, req_ready, fill_data, resp_data);
    end
    for (int k = 0; k < 4; k++) dwords[k] = 32'h1000 + 32'(k);
    lat = '{1, 1, 1, 1};
    run_txn(32'h0000_1238, 0, 0, 0);
    tests_run++;
    if (fill_data_q !== exp_line() || resp_data_q !== exp_line() || fill_cnt != 1) begin
      tests_failed++;
      $display("FAIL midrst_clean: got fill=%h resp=%h cnt=%0d want %h/1",
               fill_data_q, resp_data_q, fill_cnt, exp_line());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    addrs = '{32'hFFFF_FFF0, 32'h0000_0000};
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 4; k++) dwords[k] = $urandom;
      lat = '{1, 1, 1, 1};
      run_txn(addrs[t], 0, 0, 0);
      tests_run++;
      if (addr_errs(addrs[t]) != 0 || fill_addr_q !== addrs[t]) begin
        tests_failed++;
        $display("FAIL b2b_addr%0d: got beats=%p fill=%h want base %h", t, got_addrs, fill_addr_q, addrs[t]);
      end
      tests_run++;
      if (fill_data_q !== exp_line() || resp_data_q !== exp_line()) begin
        tests_failed++;
        $display("FAIL b2b_data%0d: got %h want %h", t, fill_data_q, exp_line());
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit na;
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      na = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        dwords[k] = $urandom;
        lat[k] = $urandom_range(1, 4);
      end
      run_txn(a, na, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      tests_run++;
      if (addr_errs(a) != 0 || overlap_err != 0 || hold_err != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_ram: got beats=%p ovl=%0d hold=%0d want base %h",
                 t, got_addrs, overlap_err, hold_err, a & 32'hFFFF_FFF0);
      end
      tests_run++;
      if (fill_cnt != (na ? 0 : 1) ||
          (!na && (fill_addr_q !== (a & 32'hFFFF_FFF0) || fill_data_q !== exp_line()))) begin
        tests_failed++;
        $display("FAIL rand%0d_fill: got cnt=%0d addr=%h data=%h want na=%b line %h",
                 t, fill_cnt, fill_addr_q, fill_data_q, na, exp_line());
      end
      tests_run++;
      if (resp_cyc != exp_resp_cyc(na) || resp_data_q !== exp_line() || stable_err != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_resp: got cyc=%0d data=%h want %0d/%h",
                 t, resp_cyc, resp_data_q, exp_resp_cyc(na), exp_line());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_alloc();
    test_slow_beat();
    test_resp_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
